// File: rtl/ext_arb_pkg.sv
// Shared opcode constants and the immediate-extension function for ext_arbiter.
package ext_arb_pkg;

  localparam logic [1:0] EOP_SIGN = 2'b00;
  localparam logic [1:0] EOP_ZERO = 2'b01;
  localparam logic [1:0] EOP_HIGH = 2'b10;
  localparam logic [1:0] EOP_SHL2 = 2'b11;

  function automatic logic [31:0] ext_apply(input logic [15:0] imm, input logic [1:0] eop);
    logic [31:0] sext;
    sext = {{16{imm[15]}}, imm};
    case (eop)
      EOP_SIGN: ext_apply = sext;
      EOP_ZERO: ext_apply = {16'h0000, imm};
      EOP_HIGH: ext_apply = {imm, 16'h0000};
      default:  ext_apply = sext << 2;
    endcase
  endfunction

endpackage

// File: rtl/ext_rr_pick.sv
// Combinational two-way round-robin picker; the port that did not win last time wins a tie.
module ext_rr_pick
  import ext_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  input  logic can_accept,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = can_accept && req0 && (!req1 || last_id);
    gnt1 = can_accept && req1 && (!req0 || !last_id);
  end

endmodule

// File: rtl/ext_arbiter.sv
// Two-port round-robin arbiter sharing one immediate-extension path, with a registered
// valid/ready result. Optional per-port grant counters are built with EXT_ARB_CNT_EN.
module ext_arbiter
  import ext_arb_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] imm0,
  input  logic [15:0] imm1,
  input  logic [1:0]  eop0,
  input  logic [1:0]  eop1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data
`ifdef EXT_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        last_id_q, last_id_d;
  logic        can_accept;

  // Reset gates the slot so requests seen during reset are never granted.
  assign can_accept = (!rsp_valid_q || rsp_ready) && !reset;

  ext_rr_pick u_pick (
    .req0      (req0),
    .req1      (req1),
    .last_id   (last_id_q),
    .can_accept(can_accept),
    .gnt0      (gnt0),
    .gnt1      (gnt1)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    last_id_d   = last_id_q;
    if (gnt0 || gnt1) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt1;
      last_id_d   = gnt1;
      rsp_data_d  = gnt1 ? ext_apply(imm1, eop1) : ext_apply(imm0, eop0);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'h0;
      last_id_q   <= 1'b1;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      last_id_q   <= last_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef EXT_ARB_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0) cnt0_d = cnt0_q + 1'b1;
    if (gnt1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// Scoreboard bench for ext_arbiter: stimulus queues expected results, a monitor pops on handshake.
module tb_ext_arbiter;

`ifdef EXT_ARB_CNT_EN
  localparam int unsigned TbCntW = 2;
`else
  localparam int unsigned TbCntW = 16;
`endif

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [15:0] imm0, imm1;
  logic [1:0]  eop0, eop1;
  logic        gnt0, gnt1;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
`ifdef EXT_ARB_CNT_EN
  logic [TbCntW-1:0] gnt_cnt0, gnt_cnt1;
`endif

  ext_arbiter #(.CNT_W(TbCntW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .imm0     (imm0),
    .imm1     (imm1),
    .eop0     (eop0),
    .eop1     (eop1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data)
`ifdef EXT_ARB_CNT_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  logic [32:0] sb[$];  // {id, data}

  logic        prev_g;
  logic [32:0] prev_exp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result must match the oldest queued expectation.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL sb_unexpected: got id %0d data %h expected nothing", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          check("sb_id", {31'h0, rsp_id}, {31'h0, e[32]});
          check("sb_data", rsp_data, e[31:0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input logic r0, input logic r1, input logic [15:0] i0,
                      input logic [1:0] e0, input logic [15:0] i1, input logic [1:0] e1,
                      input logic rdy, input logic [1:0] eg, input logic [31:0] ed,
                      input string nm);
    req0 = r0; req1 = r1; imm0 = i0; eop0 = e0; imm1 = i1; eop1 = e1; rsp_ready = rdy;
    @(negedge clk);
    if (prev_g) begin
      check({nm, "_lat_valid"}, {31'h0, rsp_valid}, 32'd1);
      check({nm, "_lat_id"}, {31'h0, rsp_id}, {31'h0, prev_exp[32]});
      check({nm, "_lat_data"}, rsp_data, prev_exp[31:0]);
    end
    check({nm, "_gnt"}, {30'h0, gnt1, gnt0}, {30'h0, eg});
    prev_g = (eg != 2'b00);
    prev_exp = {eg[1], ed};
    if (prev_g) sb.push_back(prev_exp);
    @(posedge clk);
    #1;
  endtask

  // One reset cycle with both ports requesting; checks no grant and cleared outputs.
  task automatic do_reset(input string nm);
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    check({nm, "_gnt"}, {30'h0, gnt1, gnt0}, 32'd0);
    sb.delete();
    prev_g = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check({nm, "_valid"}, {31'h0, rsp_valid}, 32'd0);
    check({nm, "_data"}, rsp_data, 32'h0);
    check({nm, "_id"}, {31'h0, rsp_id}, 32'd0);
  endtask

  initial begin
    prev_g = 1'b0;
    prev_exp = '0;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; rsp_ready = 1'b1;
    imm0 = '0; imm1 = '0; eop0 = '0; eop1 = '0;
    @(posedge clk);
    #1;
    do_reset("rst0");

    // Each opcode on port 0, then a positive shift on port 1.
    step(1, 0, 16'h8001, 2'b00, 16'h0, 2'b00, 1, 2'b01, 32'hFFFF8001, "sign");
    step(1, 0, 16'h8001, 2'b01, 16'h0, 2'b00, 1, 2'b01, 32'h00008001, "zero");
    step(1, 0, 16'h8001, 2'b10, 16'h0, 2'b00, 1, 2'b01, 32'h80010000, "high");
    step(1, 0, 16'h8001, 2'b11, 16'h0, 2'b00, 1, 2'b01, 32'hFFFE0004, "shl2");
    step(0, 1, 16'h0, 2'b00, 16'h0004, 2'b11, 1, 2'b10, 32'h00000010, "p1shl");
    step(0, 0, 16'h0, 2'b00, 16'h0, 2'b00, 1, 2'b00, 32'h0, "idle0");

    // Tie after reset alternates starting with port 0.
    do_reset("rst1");
    step(1, 1, 16'h1111, 2'b01, 16'h2222, 2'b10, 1, 2'b01, 32'h00001111, "tie0");
    step(1, 1, 16'h1111, 2'b01, 16'h2222, 2'b10, 1, 2'b10, 32'h22220000, "tie1");
    step(1, 1, 16'h1111, 2'b01, 16'h2222, 2'b10, 1, 2'b01, 32'h00001111, "tie2");
    step(1, 1, 16'h1111, 2'b01, 16'h2222, 2'b10, 1, 2'b10, 32'h22220000, "tie3");

    // Back-pressure: result held, port 1 waits, then granted with no bubble.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'h0, 2'b00, 16'h00FF, 2'b00, 0, 2'b00, 32'h0, "stall");
      check("stall_hold_valid", {31'h0, rsp_valid}, 32'd1);
      check("stall_hold_data", rsp_data, 32'h22220000);
    end
    step(0, 1, 16'h0, 2'b00, 16'h00FF, 2'b00, 1, 2'b10, 32'h000000FF, "release");
    step(0, 0, 16'h0, 2'b00, 16'h0, 2'b00, 1, 2'b00, 32'h0, "idle1");

    // Reset while a result is pending and both ports request.
    step(1, 1, 16'hABCD, 2'b00, 16'h1234, 2'b01, 0, 2'b01, 32'hFFFFABCD, "pre_rst");
    do_reset("rst2");
    step(1, 1, 16'hABCD, 2'b00, 16'h1234, 2'b01, 1, 2'b01, 32'hFFFFABCD, "post_rst");
    step(0, 0, 16'h0, 2'b00, 16'h0, 2'b00, 1, 2'b00, 32'h0, "idle2");

`ifdef EXT_ARB_CNT_EN
    do_reset("rst3");
    for (int i = 0; i < 5; i++)
      step(1, 0, 16'h0001, 2'b01, 16'h0, 2'b00, 1, 2'b01, 32'h00000001, "cnt");
    step(0, 0, 16'h0, 2'b00, 16'h0, 2'b00, 1, 2'b00, 32'h0, "idle3");
    check("gnt_cnt0", {30'h0, gnt_cnt0}, 32'd1);
    check("gnt_cnt1", {30'h0, gnt_cnt1}, 32'd0);
`endif

    step(0, 0, 16'h0, 2'b00, 16'h0, 2'b00, 1, 2'b00, 32'h0, "tail");
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ext_arbiter.md
# ext_arbiter

Two-port arbiter and result register that shares one immediate-extension datapath between two requesters (decode-stage immediate path, port 0; branch-target path, port 1). Grants at most one request per cycle using round-robin priority. Computes the 32-bit extended value in the grant cycle and holds it in a single output register under a valid/ready handshake, so a stalled consumer back-pressures both requesters.

## Interface
- Parameter `CNT_W`, default 16: width of the per-port grant counters (used only when counters are compiled in).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req0` / `req1`, input, 1: request from port 0 / port 1.
- `imm0` / `imm1`, input, 16: immediate operand for each port.
- `eop0` / `eop1`, input, 2: extension opcode for each port.
- `gnt0` / `gnt1`, output, 1: combinational grant; the request is accepted on this cycle's edge.
- `rsp_valid`, output, 1: result register holds a valid value.
- `rsp_ready`, input, 1: consumer accepts the result this cycle.
- `rsp_id`, output, 1: port that produced the current result.
- `rsp_data`, output, 32: extended result.
- `gnt_cnt0` / `gnt_cnt1`, output, `CNT_W`: grant counters; present only with `EXT_ARB_CNT_EN`.

## Operation
- Extension function, selected by `eop`:
  - 00: sign-extend `imm` to 32 bits.
  - 01: zero-extend.
  - 10: `{imm, 16'h0000}`.
  - 11: sign-extend, then shift left by 2 (the upper bits are lost).
  - All four codes are defined.
- Slot free condition: `can_accept = !rsp_valid || rsp_ready`.
- Grant rules:
  - Only one request: grant it if `can_accept`.
  - Both requests: grant the port not equal to `last_id`.
  - Not `can_accept`: no grant.
  - `gnt0` and `gnt1` are never both 1.
- On a grant edge:
  - `rsp_data` takes the extended value of the granted port's `imm`/`eop` as sampled that cycle.
  - `rsp_id` takes the granted port.
  - `rsp_valid` is set to 1.
  - `last_id` takes the granted port.
- Drain without a grant: when `rsp_valid && rsp_ready` and there is no grant, `rsp_valid` clears to 0. `rsp_data` and `rsp_id` hold their values.
- Stall: when `rsp_valid && !rsp_ready`, `rsp_data`, `rsp_id` and `rsp_valid` are all held.
- Requester rules:
  - Keep `req`, `imm` and `eop` stable until the grant.
  - Dropping `req` before the grant is legal and has no side effects.
- A requester that holds `req` is served within 2 grant opportunities.

## Timing
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `last_id`=1 (port 0 wins the first tie), counters=0. `gnt0`/`gnt1` are 0 during reset.
- Latency: a grant in cycle N makes the result visible with `rsp_valid`=1 in cycle N+1.
- Throughput: with `rsp_ready` held at 1, one result per cycle.
- Simultaneous drain and grant: the new result replaces the old one, with no bubble.
- `gnt` depends combinationally on `req`, `rsp_valid`, `rsp_ready` and `last_id`. There is no combinational path from `imm`/`eop` to `gnt`.
- Reset in the middle of traffic:
  - A pending response is discarded.
  - Requests asserted during the reset cycle are not granted.
  - They are eligible from the first cycle after `reset` deasserts.

## Configuration
- Macro: `EXT_ARB_CNT_EN`.
- Defined:
  - `gnt_cnt0` and `gnt_cnt1` exist.
  - Each counter increments by 1 on every edge where its port is granted.
  - The counters wrap modulo 2^`CNT_W`.
  - They clear on reset.
- Undefined: the counter ports and registers are absent. All other behaviour is identical.

## Structure
- Package `ext_arb_pkg`:
  - Opcode constants `EOP_SIGN`=2'b00, `EOP_ZERO`=2'b01, `EOP_HIGH`=2'b10, `EOP_SHL2`=2'b11.
  - Pure function `ext_apply(imm, eop)` returning 32 bits.
- Sub-module `ext_rr_pick`: combinational two-way round-robin picker. Inputs: `req0`, `req1`, `last_id`, `can_accept`. Outputs: `gnt0`, `gnt1`.
- All registers live in `ext_arbiter`.

## Test plan
- Each opcode on port 0 alone, `rsp_ready`=1:
  - `imm0`=16'h8001, `eop0`=00 gives `rsp_data`=32'hFFFF8001.
  - `eop0`=01 gives 32'h00008001.
  - `eop0`=10 gives 32'h80010000.
  - `eop0`=11 gives 32'hFFFE0004.
  - Each result appears one cycle after the grant, with `rsp_id`=0.
- Positive shift, port 1 alone: `imm1`=16'h0004, `eop1`=11 gives 32'h00000010 with `rsp_id`=1.
- Tie after reset: `req0`=`req1`=1 held for 4 cycles with `rsp_ready`=1. Grants must go 0, 1, 0, 1, and `rsp_id` follows one cycle later.
- Back-pressure:
  - One result is valid and `rsp_ready`=0 for 3 cycles while `req1`=1.
  - Expect `gnt1`=0 and `rsp_data` held unchanged for all 3 cycles.
  - On the cycle `rsp_ready`=1, `gnt1`=1, and the new data appears the next cycle with no bubble.
- Reset mid-operation:
  - Assert `reset` for one cycle while `rsp_valid`=1 and both ports are requesting.
  - Next cycle: `rsp_valid`=0, `rsp_data`=0, and port 0 wins the following tie.
- With `EXT_ARB_CNT_EN` and `CNT_W`=2: 5 grants to port 0 give `gnt_cnt0`=1 (wrapped), with `gnt_cnt1`=0.
